// File: rtl/vga_pkg.sv
// Shared VGA frame constants, RGB332 bar palette and the frame-loader state type.
// The display stage reuses VGA_XRES/VGA_YRES from here.
package vga_pkg;

  localparam int VGA_XRES = 640;
  localparam int VGA_YRES = 480;

  localparam logic [7:0] PAL_WHITE   = 8'hFF;
  localparam logic [7:0] PAL_YELLOW  = 8'hFC;
  localparam logic [7:0] PAL_CYAN    = 8'h1F;
  localparam logic [7:0] PAL_GREEN   = 8'h1C;
  localparam logic [7:0] PAL_MAGENTA = 8'hE3;
  localparam logic [7:0] PAL_RED     = 8'hE0;
  localparam logic [7:0] PAL_BLUE    = 8'h03;
  localparam logic [7:0] PAL_BLACK   = 8'h00;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, FILL, DONE} fl_state_t;

  function automatic logic [7:0] pal_color(input logic [2:0] idx);
    logic [7:0] c;
    unique case (idx)
      3'd0:    c = PAL_WHITE;
      3'd1:    c = PAL_YELLOW;
      3'd2:    c = PAL_CYAN;
      3'd3:    c = PAL_GREEN;
      3'd4:    c = PAL_MAGENTA;
      3'd5:    c = PAL_RED;
      3'd6:    c = PAL_BLUE;
      default: c = PAL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Stream input and frame-RAM write port of the frame loader.
// master = loader side, slave = stream source / RAM side.
interface frame_loader_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_sof;
  logic                  s_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    input  s_data, s_valid, s_sof,
    output s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output s_data, s_valid, s_sof,
    input  s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bar_pattern_gen.sv
// Colour-bar generator: tracks the bar index alongside the loader's x counter
// so no divider is needed; bar index saturates at the last palette entry.
module bar_pattern_gen
  import vga_pkg::*;
#(
  parameter int BAR_W = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       step_i,
  input  logic       wrap_i,
  output logic [7:0] color_o
);

  localparam int CW = $clog2(BAR_W + 1);

  logic [CW-1:0] within_q;
  logic [2:0]    bar_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i || (step_i && wrap_i)) begin
      within_q <= '0;
      bar_q    <= '0;
    end else if (step_i) begin
      if (within_q == CW'(BAR_W - 1)) begin
        within_q <= '0;
        if (bar_q != 3'd7) bar_q <= bar_q + 3'd1;
      end else begin
        within_q <= within_q + CW'(1);
      end
    end
  end

  assign color_o = pal_color(bar_q);

endmodule

// File: rtl/frame_loader.sv
// Frame RAM writer: one full frame per start, from the byte stream or the bar pattern.
//   state    | meaning
//   IDLE     | no writes, waiting for start
//   WAIT_SOF | stream mode, dropping beats until start-of-frame
//   FILL     | writing pixels (last_q: final write issued, draining)
//   DONE     | one-cycle done pulse, then back to IDLE
module frame_loader
  import vga_pkg::*;
#(
  parameter int XRES       = VGA_XRES,
  parameter int YRES       = VGA_YRES,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int BAR_W      = 80
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  frame_loader_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           sof_err
);

  localparam int NPIX = XRES * YRES;
  localparam int XW   = (XRES > 1) ? $clog2(XRES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(XRES - 1);

  fl_state_t             state_q;
  logic [XW-1:0]         x_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mode_q;
  logic                  last_q;
  logic                  s_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sof_err_q;

  logic [7:0]    bar_color;
  logic          pat_step;
  logic          accept;
  logic [XW-1:0] x_next;

  assign pat_step = (state_q == FILL) && mode_q && !last_q;
  assign accept   = bus.s_valid && s_ready_q;
  assign x_next   = (x_q == LAST_X) ? '0 : x_q + XW'(1);

  bar_pattern_gen #(.BAR_W(BAR_W)) u_bar (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == IDLE && start),
    .step_i  (pat_step),
    .wrap_i  (x_q == LAST_X),
    .color_o (bar_color)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      addr_q    <= '0;
      mode_q    <= 1'b0;
      last_q    <= 1'b0;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      sof_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x_q       <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            mode_q    <= mode;
            busy_q    <= 1'b1;
            s_ready_q <= !mode;
            state_q   <= mode ? FILL : WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (accept && bus.s_sof) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= bus.s_data;
            addr_q    <= ADDR_WIDTH'(1);
            x_q       <= XW'(1);
            state_q   <= FILL;
          end
        end
        FILL: begin
          // Hold FILL one extra cycle after the last write so done lands one cycle after it.
          if (last_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (mode_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= DATA_WIDTH'(bar_color);
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            x_q       <= x_next;
            if (addr_q == LAST_ADDR) last_q <= 1'b1;
          end else if (accept) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= bus.s_data;
            if (bus.s_sof) begin
              wr_addr_q <= '0;
              sof_err_q <= 1'b1;
              addr_q    <= ADDR_WIDTH'(1);
              x_q       <= XW'(1);
            end else begin
              wr_addr_q <= addr_q;
              addr_q    <= addr_q + ADDR_WIDTH'(1);
              x_q       <= x_next;
              if (addr_q == LAST_ADDR) begin
                last_q    <= 1'b1;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader on a reduced 80x30 frame, checked against
// an address/pixel reference model and a write monitor.
module tb_frame_loader;

  localparam int XR   = 80;
  localparam int YR   = 30;
  localparam int BW   = 10;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int NPIX = XR * YR;

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         cyc;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       sof;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic busy, done, sof_err;

  frame_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  frame_loader #(
    .XRES(XR), .YRES(YR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BAR_W(BW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .sof_err (sof_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] pal [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  function automatic logic [7:0] ref_pix(input int a);
    int bar;
    bar = (a % XR) / BW;
    if (bar > 7) bar = 7;
    return pal[bar];
  endfunction

  // write monitor
  logic [7:0] got_mem [NPIX];
  exp_t exp_q [$];
  exp_t mon_e;
  bit   pat_mode;
  int   wr_count, wr_bad, first_wr_cyc, last_wr_cyc;
  int   done_cnt, done_cyc, sof_err_cnt, sof_err_at0;

  task automatic clear_mon(input bit pm);
    pat_mode     = pm;
    wr_count     = 0;
    wr_bad       = 0;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    done_cnt     = 0;
    done_cyc     = -1;
    sof_err_cnt  = 0;
    sof_err_at0  = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sof_err) begin
      sof_err_cnt++;
      if (bus.wr_en && bus.wr_addr == '0) sof_err_at0++;
    end
    if (bus.wr_en) begin
      if (wr_count == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (int'(bus.wr_addr) < NPIX) got_mem[bus.wr_addr] = bus.wr_data;
      else wr_bad++;
      if (pat_mode) begin
        if (int'(bus.wr_addr) != wr_count || bus.wr_data != ref_pix(int'(bus.wr_addr)) ||
            cyc != first_wr_cyc + wr_count || sof_err)
          wr_bad++;
      end else if (exp_q.size() == 0) begin
        wr_bad++;
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.addr != int'(bus.wr_addr) || mon_e.data != bus.wr_data ||
            mon_e.cyc != cyc || mon_e.err != sof_err)
          wr_bad++;
      end
      wr_count++;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    check_val({tag, "_wr_en"},   32'(bus.wr_en),   0);
    check_val({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check_val({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    check_val({tag, "_busy"},    32'(busy),        0);
    check_val({tag, "_done"},    32'(done),        0);
    check_val({tag, "_sof_err"}, 32'(sof_err),     0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) check_val({tag, "_done_timeout"}, 0, 1);
  endtask

  // Drives the beat list with random valid gaps; the reference pointer p is -1
  // until the first SOF, then the linear address of the next pixel.
  task automatic run_stream(input int n_pre, input int mid_at, output logic [7:0] mid_next);
    beat_t beats [$];
    beat_t b;
    int idx, p, k;
    mid_next = 8'h00;
    for (int i = 0; i < n_pre; i++) beats.push_back('{data: 8'($urandom), sof: 1'b0});
    beats.push_back('{data: 8'hAA, sof: 1'b1});
    if (mid_at > 0) begin
      for (int i = 1; i < mid_at; i++) beats.push_back('{data: 8'($urandom), sof: 1'b0});
      beats.push_back('{data: 8'h5A, sof: 1'b1});
    end
    for (int i = 1; i < NPIX; i++) beats.push_back('{data: 8'($urandom), sof: 1'b0});
    if (mid_at > 0) mid_next = beats[n_pre + mid_at + 1].data;

    clear_mon(1'b0);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b1;
    idx = 0;
    p   = -1;
    k   = 0;
    while (p < NPIX && k < 8 * NPIX + 8 * mid_at) begin
      @(negedge clk);
      k++;
      if ($urandom_range(0, 1) == 1) begin
        b = beats[idx];
        bus.s_valid = 1'b1;
        bus.s_data  = b.data;
        bus.s_sof   = b.sof;
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        bus.s_sof   = 1'($urandom_range(0, 1));
      end
      if (bus.s_valid && bus.s_ready) begin
        if (b.sof) begin
          exp_q.push_back('{addr: 0, data: b.data, cyc: cyc + 1, err: (p > 0)});
          p = 1;
        end else if (p >= 0) begin
          exp_q.push_back('{addr: p, data: b.data, cyc: cyc + 1, err: 1'b0});
          p++;
        end
        idx++;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    if (p < NPIX) check_val("stream_feed_timeout", 32'(p), 32'(NPIX));
    wait_done(40, "stream");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s_cyc, n0, k;
    logic [7:0] mid_next;

    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_sof = 1'b0;
    clear_mon(1'b1);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // pattern frame, single start pulse; mode toggles during the fill are ignored
    clear_mon(1'b1);
    start = 1'b1;
    mode  = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
    check_val("pat_busy_after_start", 32'(busy), 1);
    check_val("pat_s_ready", 32'(bus.s_ready), 0);
    wait_done(NPIX + 20, "pat1");
    @(negedge clk);
    check_val("pat_busy_low_m2", 32'(busy), 0);
    check_val("pat_first_wr_cyc", 32'(first_wr_cyc), 32'(s_cyc + 2));
    check_val("pat_wr_count", 32'(wr_count), 32'(NPIX));
    check_val("pat_wr_bad", 32'(wr_bad), 0);
    check_val("pat_done_cnt", 32'(done_cnt), 1);
    check_val("pat_done_latency", 32'(done_cyc), 32'(last_wr_cyc + 1));
    check_val("pat_sof_err_cnt", 32'(sof_err_cnt), 0);
    check_val("pat_px0", 32'(got_mem[0]), 32'h FF);
    check_val("pat_px9", 32'(got_mem[BW - 1]), 32'h FF);
    check_val("pat_px10", 32'(got_mem[BW]), 32'h FC);
    check_val("pat_px_xlast", 32'(got_mem[XR - 1]), 32'h00);
    check_val("pat_px_line1", 32'(got_mem[XR]), 32'hFF);
    check_val("pat_px_last", 32'(got_mem[NPIX - 1]), 32'h00);

    // start accepted at M+2, then held high through the fill: no restart
    clear_mon(1'b1);
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    check_val("held_busy_accept", 32'(busy), 1);
    wait_done(NPIX + 20, "held");
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_val("held_wr_count", 32'(wr_count), 32'(NPIX));
    check_val("held_wr_bad", 32'(wr_bad), 0);
    check_val("held_done_cnt", 32'(done_cnt), 1);
    check_val("held_busy_idle", 32'(busy), 0);

    // stream: 5 non-SOF beats dropped, SOF byte AA at address 0
    run_stream(5, 0, mid_next);
    check_val("strm_wr_count", 32'(wr_count), 32'(NPIX));
    check_val("strm_wr_bad", 32'(wr_bad), 0);
    check_val("strm_exp_left", 32'(exp_q.size()), 0);
    check_val("strm_px0", 32'(got_mem[0]), 32'hAA);
    check_val("strm_sof_err_cnt", 32'(sof_err_cnt), 0);
    check_val("strm_done_cnt", 32'(done_cnt), 1);
    check_val("strm_busy_idle", 32'(busy), 0);

    // stream: unexpected SOF at counter 1000 restarts the frame
    run_stream(0, 1000, mid_next);
    check_val("midsof_wr_count", 32'(wr_count), 32'(NPIX + 1000));
    check_val("midsof_wr_bad", 32'(wr_bad), 0);
    check_val("midsof_exp_left", 32'(exp_q.size()), 0);
    check_val("midsof_err_cnt", 32'(sof_err_cnt), 1);
    check_val("midsof_err_at_addr0", 32'(sof_err_at0), 1);
    check_val("midsof_px0", 32'(got_mem[0]), 32'h5A);
    check_val("midsof_px1", 32'(got_mem[1]), 32'(mid_next));
    check_val("midsof_done_cnt", 32'(done_cnt), 1);

    // reset in the middle of a pattern fill
    clear_mon(1'b1);
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(bus.wr_en && bus.wr_addr == AW'(500)) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check_val("rst_wait_addr500_timeout", 32'(k), 0);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    n0 = wr_count;
    repeat (20) @(negedge clk);
    check_val("midrst_no_writes", 32'(wr_count), 32'(n0));
    check_val("midrst_idle", 32'(busy), 0);
    clear_mon(1'b1);
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(NPIX + 20, "restart");
    repeat (3) @(negedge clk);
    check_val("restart_wr_count", 32'(wr_count), 32'(NPIX));
    check_val("restart_wr_bad", 32'(wr_bad), 0);
    check_val("restart_px0", 32'(got_mem[0]), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
# frame_loader

Upstream writer for the 640x480, 8-bit-per-pixel (RGB332) frame RAM that the VGA display stage scans out. Fills the RAM write port either from a byte stream (valid/ready handshake, start-of-frame marker) or from an internal 8-bar colour test pattern, one full frame per `start` command. It owns only the write port; the display stage keeps the read port.

## Interface
Parameters:
- `XRES`, 640, active pixels per line
- `YRES`, 480, active lines per frame
- `ADDR_WIDTH`, 19, RAM address width; must satisfy XRES*YRES <= 2^ADDR_WIDTH
- `DATA_WIDTH`, 8, pixel width (RGB332)
- `BAR_W`, 80, test-pattern bar width in pixels

Ports:
- `clk`  in  1  system clock. Reset is synchronous and active-high; `clk` is the only clock.
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin one frame fill; sampled only in IDLE
- `mode`  in  1  0 = stream, 1 = test pattern; latched on accepted `start`
- `s_data`  in  DATA_WIDTH  stream pixel
- `s_valid`  in  1  stream pixel valid
- `s_sof`  in  1  qualifies `s_data` as pixel (0,0)
- `s_ready`  out  1  stream pixel accepted when `s_valid & s_ready`
- `wr_en`  out  1  RAM write strobe
- `wr_addr`  out  ADDR_WIDTH  RAM write address, linear y*XRES+x
- `wr_data`  out  DATA_WIDTH  RAM write data
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse after final pixel written
- `sof_err`  out  1  one-cycle pulse on unexpected mid-frame SOF

## Operation
- States: IDLE, WAIT_SOF, FILL, DONE.
- IDLE: `s_ready`=0, no writes. `start`=1: clear x, y and address counters; latch `mode`; go to WAIT_SOF if stream, FILL if pattern.
- WAIT_SOF (stream): `s_ready`=1; accepted beats with `s_sof`=0 are discarded; accepted beat with `s_sof`=1 is written at address 0; go to FILL, counter = 1.
- FILL, stream: `s_ready`=1; each accepted beat is written at the current address and the counters advance. No write occurs without an accepted beat, so valid gaps stall the fill. An accepted beat with `s_sof`=1 at counter != 0 pulses `sof_err`, is written at address 0, and the counter restarts at 1.
- FILL, pattern: one write per cycle, unconditionally. `s_ready`=0. `wr_data` = palette[x / BAR_W], palette = FF, FC, 1F, 1C, E3, E0, 03, 00. x wraps at XRES-1 -> 0 with y+1.
- Write of address XRES*YRES-1 -> DONE (1 cycle, `done`=1) -> IDLE.
- Exactly XRES*YRES writes per good frame. Address never exceeds XRES*YRES-1.
- `start` while busy is ignored. `mode` changes while busy are ignored.
- `rst` in any state: IDLE, counters 0, next write requires a new `start`.

## Timing
- Reset values: `s_ready`, `wr_en`, `busy`, `done`, `sof_err` = 0; `wr_addr`, `wr_data` = 0.
- `wr_en`, `wr_addr` and `wr_data` are registered. A beat accepted in cycle N, or a pattern pixel issued in cycle N, appears on the write port in cycle N+1.
- `s_ready` is a registered function of state; it does not depend combinationally on `s_valid`.
- `start` in IDLE at cycle N: `busy`=1 from N+1. In pattern mode the first write (addr 0) appears at N+2.
- Last write at cycle M: `done`=1 at M+1, `busy`=0 at M+2. A `start` at M+2 is accepted.
- `sof_err` is asserted in the same cycle as the corresponding write to address 0.
- Pattern frame duration: XRES*YRES write cycles. At defaults this is 307200.

## Structure
- Shared package `vga_pkg`: XRES, YRES defaults, RGB332 palette constants, state enum typedef. The display stage reuses XRES and YRES from this package.
- One sub-module, `bar_pattern_gen`: maps x to the palette entry (divider-free bar counter, wraps at XRES). Counters, FSM and write-port registers stay in `frame_loader`.

## Test plan
- Pattern mode, defaults, `start` pulse: writes at addr 0 = FF, 79 = FF, 80 = FC, 639 = 00, 640 = FF, 307199 = 00. Exactly 307200 writes; `done` occurs 1 cycle after the addr-307199 write.
- Stream mode, `s_valid` toggling 1/0 randomly: nth accepted byte lands at addr n-1 with 1-cycle latency. No writes occur in gap cycles.
- Stream, 5 beats with `s_sof`=0 then SOF beat AA: the first 5 beats are dropped and addr 0 = AA.
- Stream, SOF arrives at counter 1000: `sof_err` pulses, that byte is written at addr 0, and the next byte is written at addr 1.
- `rst` asserted at pattern address 5000: next cycle all outputs are 0 and state is IDLE. A new `start` restarts writing at addr 0.
- `start` held high during a fill: no restart. `done` pulses once per frame; a second frame starts only when `start` is seen in IDLE.
